// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// default memory size and the funct3 legality check.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_LIMIT = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_CAP,
    ST_WR,
    RMW_RD,
    RMW_WR,
    ERR
  } lsu_state_t;

  // Stores only have signed-looking codes; the unsigned variants exist for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bundle between the pipeline's memory stage (master) and
// the load/store unit (slave).
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Load result formatting: picks the low byte/half of the memory word and
// sign- or zero-extends it according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_funct3)
      F3_B:    o_result = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_H:    o_result = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_W:    o_result = i_raw;
      F3_BU:   o_result = {24'h000000, i_raw[7:0]};
      F3_HU:   o_result = {16'h0000, i_raw[15:0]};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request at a time, sub-word stores done as
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = LSU_ADDR_LIMIT
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_write_data,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [31:0]         mem_read_data
);

  lsu_state_t  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_rdata;

  lsu_state_t  w_start;
  logic        w_accept;
  logic        w_misaligned;
  logic [31:0] w_ext;

  assign bus.req_ready = (r_state == IDLE) && rst_n;
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    w_misaligned = (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0]) ||
                   ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
`else
    w_misaligned = 1'b0;
`endif
    w_start = IDLE;
    if (!f3_legal(bus.req_we, bus.req_funct3) ||
        (bus.req_addr > 32'(ADDR_LIMIT - 4)) || w_misaligned)
      w_start = ERR;
    else if (!bus.req_we)
      w_start = LD_RD;
    else if (bus.req_funct3 == F3_W)
      w_start = ST_WR;
    else
      w_start = RMW_RD;
  end

  lsu_load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_raw    (mem_read_data),
    .o_result (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_we         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_funct3 <= bus.req_funct3;
            r_we     <= bus.req_we;
            r_state  <= w_start;
          end
        end
        LD_RD:  r_state <= LD_CAP;
        LD_CAP: begin
          r_rdata      <= w_ext;
          r_resp_valid <= 1'b1;
          r_state      <= IDLE;
        end
        ST_WR, RMW_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= IDLE;
        end
        RMW_RD: r_state <= RMW_WR;
        ERR: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Registered results are masked while reset is held so nothing leaks mid-reset.
  assign bus.resp_valid = r_resp_valid && rst_n;
  assign bus.resp_err   = r_resp_err && rst_n;
  assign bus.resp_rdata = rst_n ? r_rdata : '0;

  // Memory word lane is always the low byte/half, so the merge needs no shifting.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (rst_n) begin
      case (r_state)
        LD_RD, RMW_RD: begin
          mem_read    = 1'b1;
          mem_address = r_addr;
        end
        ST_WR: begin
          mem_write      = r_we;
          mem_address    = r_addr;
          mem_write_data = r_wdata;
        end
        RMW_WR: begin
          mem_write      = r_we;
          mem_address    = r_addr;
          mem_write_data = (r_funct3 == F3_H) ? {mem_read_data[31:16], r_wdata[15:0]}
                                              : {mem_read_data[31:8], r_wdata[7:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-addressed memory model;
// expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  load_store_unit #(.ADDR_LIMIT(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  // Registered data memory; preloaded on the first clock edge.
  logic [7:0] mem [0:1023];
  logic       memLoaded = 1'b0;
  logic [9:0] memA;
  assign memA = mem_address[9:0];

  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[16] <= 8'hF0;
      mem[17] <= 8'hF0;
      mem[18] <= 8'h81;
      mem[19] <= 8'h80;
      mem[20] <= 8'h00;
      memLoaded <= 1'b1;
    end else if (mem_write) begin
      for (int i = 0; i < 4; i++) mem[memA + 10'(i)] <= mem_write_data[8*i +: 8];
    end
    mem_read_data <= mem_read ? {mem[memA + 10'd3], mem[memA + 10'd2], mem[memA + 10'd1], mem[memA]}
                              : 32'h0;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int nReads = 0;
  int nWrites = 0;
  int lastReadCyc = 0;
  int lastWriteCyc = 0;
  logic [31:0] lastWriteData = '0;

  // Strobe bookkeeping and scoreboard comparison of every response.
  always @(negedge clk) begin
    exp_t e;
    if (mem_read || mem_write) begin
      checks = checks + 1;
      if ((mem_read && mem_write) || (mem_address > 32'd1020)) begin
        errors = errors + 1;
        $display("[TB] FAIL strobe_sanity: rd=%b wr=%b addr=%h, required exclusive strobes and addr<=3FC",
                 mem_read, mem_write, mem_address);
      end
    end
    if (mem_read) begin
      nReads = nReads + 1;
      lastReadCyc = cyc;
    end
    if (mem_write) begin
      nWrites = nWrites + 1;
      lastWriteCyc = cyc;
      lastWriteData = mem_write_data;
    end
    if (bus.resp_valid) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("[TB] FAIL unexpected_resp: got resp_valid with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        checks = checks + 3;
        if (bus.resp_rdata !== e.rdata) begin
          errors = errors + 1;
          $display("[TB] FAIL %s rdata: got %h want %h", e.name, bus.resp_rdata, e.rdata);
        end
        if (bus.resp_err !== e.err) begin
          errors = errors + 1;
          $display("[TB] FAIL %s err: got %b want %b", e.name, bus.resp_err, e.err);
        end
        if ((cyc - e.acc) != e.lat) begin
          errors = errors + 1;
          $display("[TB] FAIL %s latency: got %0d want %0d", e.name, cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Called at a negedge; holds the request until accepted and queues its expectation.
  task automatic presentReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] expRdata,
                            input logic expErr, input int expLat, input string name,
                            output int accCyc);
    int waitCnt = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    while (!bus.req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.req_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL %s accept: req_ready stayed %b, required 1", name, bus.req_ready);
      bus.req_valid = 1'b0;
      accCyc = -1;
      return;
    end
    accCyc = cyc;
    sb.push_back('{rdata: expRdata, err: expErr, lat: expLat, acc: accCyc, name: name});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input logic expErr, input int expLat, input string name,
                               output int accCyc);
    @(negedge clk);
    presentReq(we, f3, addr, wdata, expRdata, expErr, expLat, name, accCyc);
  endtask

  task automatic waitDone();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL resp_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks = checks + 2;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, mem_read, mem_write} !== 5'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL reset_flags: got rdy/vld/err/rd/wr=%b want 00000",
               {bus.req_ready, bus.resp_valid, bus.resp_err, mem_read, mem_write});
    end
    if ({bus.resp_rdata, mem_address, mem_write_data} !== 96'h0) begin
      errors = errors + 1;
      $display("[TB] FAIL reset_buses: got rdata=%h addr=%h wdata=%h want all 0",
               bus.resp_rdata, mem_address, mem_write_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (bus.req_ready !== 1'b1) begin
      errors = errors + 1;
      $display("[TB] FAIL ready_after_reset: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
    logic [31:0] adrs [5] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10};
    logic [31:0] exps [5] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8081, 32'h00008081, 32'h8081F0F0};
    int acc, r0, w0;
    for (int i = 0; i < 5; i++) begin
      r0 = nReads;
      w0 = nWrites;
      applyStimulus(1'b0, f3s[i], adrs[i], 32'h0, exps[i], 1'b0, 3, $sformatf("load%0d", i), acc);
      waitDone();
      checks = checks + 2;
      if ((nReads - r0) != 1 || (lastReadCyc - acc) != 1) begin
        errors = errors + 1;
        $display("[TB] FAIL load%0d read_strobe: got %0d reads at cycle %0d, want 1 at cycle 1",
                 i, nReads - r0, lastReadCyc - acc);
      end
      if (nWrites != w0) begin
        errors = errors + 1;
        $display("[TB] FAIL load%0d no_write: got %0d writes want 0", i, nWrites - w0);
      end
    end
  endtask

  task automatic test_sub_word_store();
    int acc, r0, w0;
    r0 = nReads;
    w0 = nWrites;
    applyStimulus(1'b1, F3_B, 32'h10, 32'h12345678, 32'h0, 1'b0, 3, "sb", acc);
    waitDone();
    checks = checks + 3;
    if ((nWrites - w0) != 1 || (lastWriteCyc - acc) != 2) begin
      errors = errors + 1;
      $display("[TB] FAIL sb write_strobe: got %0d writes at cycle %0d, want 1 at cycle 2",
               nWrites - w0, lastWriteCyc - acc);
    end
    if (lastWriteData !== 32'h8081F078) begin
      errors = errors + 1;
      $display("[TB] FAIL sb merge: got %h want 8081f078", lastWriteData);
    end
    if ((nReads - r0) != 1 || (lastReadCyc - acc) != 1) begin
      errors = errors + 1;
      $display("[TB] FAIL sb read_strobe: got %0d reads at cycle %0d, want 1 at cycle 1",
               nReads - r0, lastReadCyc - acc);
    end
    applyStimulus(1'b0, F3_W, 32'h10, 32'h0, 32'h8081F078, 1'b0, 3, "sb_readback", acc);
    applyStimulus(1'b1, F3_H, 32'h20, 32'hABCD1234, 32'h0, 1'b0, 3, "sh", acc);
    applyStimulus(1'b0, F3_W, 32'h20, 32'h0, 32'h00001234, 1'b0, 3, "sh_readback", acc);
    applyStimulus(1'b1, F3_B, 32'h10, 32'h000000F0, 32'h0, 1'b0, 3, "sb_restore", acc);
    applyStimulus(1'b0, F3_W, 32'h10, 32'h0, 32'h8081F0F0, 1'b0, 3, "restore_readback", acc);
    waitDone();
  endtask

  task automatic test_addr_limit();
    int acc, r0, w0;
    w0 = nWrites;
    applyStimulus(1'b1, F3_W, 32'h3FC, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_top", acc);
    waitDone();
    checks = checks + 2;
    if ((nWrites - w0) != 1 || (lastWriteCyc - acc) != 1) begin
      errors = errors + 1;
      $display("[TB] FAIL sw_top write_strobe: got %0d writes at cycle %0d, want 1 at cycle 1",
               nWrites - w0, lastWriteCyc - acc);
    end
    if (lastWriteData !== 32'hDEADBEEF) begin
      errors = errors + 1;
      $display("[TB] FAIL sw_top wdata: got %h want deadbeef", lastWriteData);
    end
    applyStimulus(1'b0, F3_W, 32'h3FC, 32'h0, 32'hDEADBEEF, 1'b0, 3, "sw_top_readback", acc);
    waitDone();
    r0 = nReads;
    w0 = nWrites;
    applyStimulus(1'b1, F3_W, 32'h3FD, 32'h11111111, 32'h0, 1'b1, 2, "sw_over", acc);
    applyStimulus(1'b0, F3_B, 32'h400, 32'h0, 32'h0, 1'b1, 2, "lb_over", acc);
    waitDone();
    checks = checks + 1;
    if (nWrites != w0 || nReads != r0) begin
      errors = errors + 1;
      $display("[TB] FAIL over_limit strobes: got %0d writes %0d reads want 0 0",
               nWrites - w0, nReads - r0);
    end
  endtask

  task automatic test_misaligned();
    int acc, r0;
    r0 = nReads;
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b0, F3_W, 32'h11, 32'h0, 32'h0, 1'b1, 2, "lw_misaligned", acc);
    waitDone();
    checks = checks + 1;
    if (nReads != r0) begin
      errors = errors + 1;
      $display("[TB] FAIL lw_misaligned no_read: got %0d reads want 0", nReads - r0);
    end
`else
    applyStimulus(1'b0, F3_W, 32'h11, 32'h0, 32'h008081F0, 1'b0, 3, "lw_misaligned", acc);
    waitDone();
    checks = checks + 1;
    if ((nReads - r0) != 1) begin
      errors = errors + 1;
      $display("[TB] FAIL lw_misaligned read: got %0d reads want 1", nReads - r0);
    end
`endif
  endtask

  task automatic test_reset_mid_rmw();
    int acc, w0;
    w0 = nWrites;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h00005555;
    checks = checks + 1;
    if (bus.req_ready !== 1'b1) begin
      errors = errors + 1;
      $display("[TB] FAIL rmw_reset accept: req_ready got %b want 1", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({mem_read, mem_write, bus.resp_valid, bus.req_ready} !== 4'b0) begin
      errors = errors + 1;
      $display("[TB] FAIL rmw_reset gated: got rd/wr/vld/rdy=%b want 0000",
               {mem_read, mem_write, bus.resp_valid, bus.req_ready});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (bus.req_ready !== 1'b1) begin
      errors = errors + 1;
      $display("[TB] FAIL rmw_reset ready_after_release: got %b want 1", bus.req_ready);
    end
    repeat (4) @(negedge clk);
    checks = checks + 1;
    if (nWrites != w0) begin
      errors = errors + 1;
      $display("[TB] FAIL rmw_reset no_write: got %0d writes want 0", nWrites - w0);
    end
    applyStimulus(1'b0, F3_W, 32'h10, 32'h0, 32'h8081F0F0, 1'b0, 3, "rmw_reset_readback", acc);
    waitDone();
  endtask

  task automatic test_back_to_back();
    int acc, acc2, r0, w0, n;
    r0 = nReads;
    w0 = nWrites;
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 2, "illegal_f3", acc);
    n = 0;
    while (!bus.resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 2;
    if (!bus.resp_valid || bus.req_ready !== 1'b1) begin
      errors = errors + 1;
      $display("[TB] FAIL b2b ready_during_resp: got vld=%b rdy=%b want 1 1", bus.resp_valid, bus.req_ready);
    end
    if (nReads != r0 || nWrites != w0) begin
      errors = errors + 1;
      $display("[TB] FAIL illegal_f3 strobes: got %0d reads %0d writes want 0 0",
               nReads - r0, nWrites - w0);
    end
    presentReq(1'b0, F3_W, 32'h10, 32'h0, 32'h8081F0F0, 1'b0, 3, "b2b_lw", acc2);
    checks = checks + 1;
    if (acc2 != acc + 2) begin
      errors = errors + 1;
      $display("[TB] FAIL b2b accept_cycle: got %0d want %0d", acc2 - acc, 2);
    end
    waitDone();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    $display("[TB] starting load_store_unit bench");
    test_reset();
    test_loads();
    test_sub_word_store();
    test_addr_limit();
    test_misaligned();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
